// File: rtl/node_core_engine_if.sv
// rtl/node_core_engine_if.sv - valid/ready channels between the node core engine and its neighbours
// Channels:
//   dg_*       generator -> engine, 8-bit {dest, payload}
//   pkt_out_*  engine -> merge, 11-bit {dest, cw}
//   ctrl_out_* engine -> arbiter, 2-bit merge-control token
//   pkt_in_*   path computation -> engine, 11-bit {addr, cw}
//   db_*       engine -> bucket, 8-bit {addr, payload}
// slave modport: engine side. master modport: environment side.
`timescale 1ns/1ps
interface node_core_engine_if;
  logic [7:0]  dg_data;
  logic        dg_valid;
  logic        dg_ready;
  logic [10:0] pkt_out_data;
  logic        pkt_out_valid;
  logic        pkt_out_ready;
  logic [1:0]  ctrl_out_data;
  logic        ctrl_out_valid;
  logic        ctrl_out_ready;
  logic [10:0] pkt_in_data;
  logic        pkt_in_valid;
  logic        pkt_in_ready;
  logic [7:0]  db_data;
  logic        db_valid;
  logic        db_ready;

  modport slave (
    input  dg_data, dg_valid, pkt_out_ready, ctrl_out_ready, pkt_in_data, pkt_in_valid, db_ready,
    output dg_ready, pkt_out_data, pkt_out_valid, ctrl_out_data, ctrl_out_valid, pkt_in_ready,
           db_data, db_valid
  );

  modport master (
    output dg_data, dg_valid, pkt_out_ready, ctrl_out_ready, pkt_in_data, pkt_in_valid, db_ready,
    input  dg_ready, pkt_out_data, pkt_out_valid, ctrl_out_data, ctrl_out_valid, pkt_in_ready,
           db_data, db_valid
  );
endinterface

// File: rtl/node_core_engine.sv
// rtl/node_core_engine.sv - NoC node core endpoint: Hamming(7,4) TX encode, RX decode, local loopback
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   bus        node_core_engine_if.slave (dg, pkt_out, ctrl_out, pkt_in, db channels)
//   tx_count   packets fully sent (pkt and ctrl both handshaken)
//   rx_count   words delivered to the bucket
//   err_count  corrected packets (only with HAMMING_CORRECT_EN)
// Build option: HAMMING_CORRECT_EN enables single-bit correction on RX and the err_count port.
`timescale 1ns/1ps
module node_core_engine #(
  parameter logic [3:0] MY_IP = 4'b0000,
  parameter int         CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  node_core_engine_if.slave bus,
  output logic [CNT_W-1:0] tx_count,
  output logic [CNT_W-1:0] rx_count
`ifdef HAMMING_CORRECT_EN
  ,
  output logic [CNT_W-1:0] err_count
`endif
);

  // cw = {d3, d2, d1, p4, d0, p2, p1}
  function automatic logic [6:0] f_encode(input logic [3:0] d);
    return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  endfunction

  logic             r_tx_full;
  logic             r_pkt_out_valid;
  logic             r_ctrl_out_valid;
  logic [10:0]      r_pkt_out_data;
  logic             r_rx_full;
  logic [7:0]       r_db_data;
  logic [CNT_W-1:0] r_tx_count;
  logic [CNT_W-1:0] r_rx_count;

  logic       w_dg_loop;
  logic       w_dg_ready;
  logic       w_dg_xfer;
  logic       w_tx_load;
  logic       w_loop_load;
  logic       w_tx_last;
  logic       w_pkt_in_xfer;
  logic       w_db_done;
  logic [6:0] w_rx_cw;
  logic [3:0] w_rx_payload;

  assign w_dg_loop = (bus.dg_data[7:4] == MY_IP);

  // A loopback word needs the RX buffer, which an incoming packet claims first.
  assign w_dg_ready    = !r_tx_full && !(w_dg_loop && (r_rx_full || bus.pkt_in_valid));
  assign w_dg_xfer     = bus.dg_valid && w_dg_ready;
  assign w_tx_load     = w_dg_xfer && !w_dg_loop;
  assign w_loop_load   = w_dg_xfer && w_dg_loop;
  assign w_pkt_in_xfer = bus.pkt_in_valid && !r_rx_full;
  assign w_db_done     = r_rx_full && bus.db_ready;

  // The TX entry frees once every output still pending completes this cycle.
  assign w_tx_last = r_tx_full
                  && (!r_pkt_out_valid  || bus.pkt_out_ready)
                  && (!r_ctrl_out_valid || bus.ctrl_out_ready);

  assign w_rx_cw = bus.pkt_in_data[6:0];

`ifdef HAMMING_CORRECT_EN
  logic [CNT_W-1:0] r_err_count;
  logic [2:0]       w_syn;
  logic [6:0]       w_cw_fix;

  // Syndrome value is the 1-based position of a single flipped bit.
  assign w_syn = {w_rx_cw[3] ^ w_rx_cw[4] ^ w_rx_cw[5] ^ w_rx_cw[6],
                  w_rx_cw[1] ^ w_rx_cw[2] ^ w_rx_cw[5] ^ w_rx_cw[6],
                  w_rx_cw[0] ^ w_rx_cw[2] ^ w_rx_cw[4] ^ w_rx_cw[6]};

  always_comb begin
    w_cw_fix = w_rx_cw;
    if (w_syn != 3'd0) begin
      w_cw_fix[w_syn - 3'd1] = ~w_rx_cw[w_syn - 3'd1];
    end
  end

  assign w_rx_payload = {w_cw_fix[6], w_cw_fix[5], w_cw_fix[4], w_cw_fix[2]};
  assign err_count    = r_err_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_count <= '0;
    end else if (w_pkt_in_xfer && (w_syn != 3'd0)) begin
      r_err_count <= r_err_count + CNT_W'(1);
    end
  end
`else
  // Parity bits are only consulted when correction is built in.
  logic w_unused_parity;
  assign w_unused_parity = ^{w_rx_cw[3], w_rx_cw[1], w_rx_cw[0]};
  assign w_rx_payload    = {w_rx_cw[6], w_rx_cw[5], w_rx_cw[4], w_rx_cw[2]};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_full        <= 1'b0;
      r_pkt_out_valid  <= 1'b0;
      r_ctrl_out_valid <= 1'b0;
      r_pkt_out_data   <= '0;
      r_rx_full        <= 1'b0;
      r_db_data        <= '0;
      r_tx_count       <= '0;
      r_rx_count       <= '0;
    end else begin
      // TX: load only happens while empty, so it never overlaps a drain.
      if (w_tx_load) begin
        r_tx_full        <= 1'b1;
        r_pkt_out_valid  <= 1'b1;
        r_ctrl_out_valid <= 1'b1;
        r_pkt_out_data   <= {bus.dg_data[7:4], f_encode(bus.dg_data[3:0])};
      end else begin
        if (r_pkt_out_valid && bus.pkt_out_ready) begin
          r_pkt_out_valid <= 1'b0;
        end
        if (r_ctrl_out_valid && bus.ctrl_out_ready) begin
          r_ctrl_out_valid <= 1'b0;
        end
        if (w_tx_last) begin
          r_tx_full  <= 1'b0;
          r_tx_count <= r_tx_count + CNT_W'(1);
        end
      end

      // RX: both fills require an empty buffer, so no fill coincides with a drain.
      if (w_pkt_in_xfer) begin
        r_rx_full <= 1'b1;
        r_db_data <= {bus.pkt_in_data[10:7], w_rx_payload};
      end else if (w_loop_load) begin
        r_rx_full <= 1'b1;
        r_db_data <= bus.dg_data;
      end else if (w_db_done) begin
        r_rx_full  <= 1'b0;
        r_rx_count <= r_rx_count + CNT_W'(1);
      end
    end
  end

  assign bus.dg_ready       = w_dg_ready;
  assign bus.pkt_out_valid  = r_pkt_out_valid;
  assign bus.pkt_out_data   = r_pkt_out_data;
  assign bus.ctrl_out_valid = r_ctrl_out_valid;
  assign bus.ctrl_out_data  = 2'b01;
  assign bus.pkt_in_ready   = !r_rx_full;
  assign bus.db_valid       = r_rx_full;
  assign bus.db_data        = r_db_data;
  assign tx_count           = r_tx_count;
  assign rx_count           = r_rx_count;

endmodule

// File: tb/tb_node_core_engine.sv
// tb/tb_node_core_engine.sv - directed and randomized self-checking bench for node_core_engine
`timescale 1ns/1ps
module tb_node_core_engine;
  localparam logic [3:0] MY_IP = 4'd2;
  localparam int         CNT_W = 4;
`ifdef HAMMING_CORRECT_EN
  localparam bit CORR = 1'b1;
`else
  localparam bit CORR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  node_core_engine_if bus();
  logic [CNT_W-1:0] tx_count;
  logic [CNT_W-1:0] rx_count;
`ifdef HAMMING_CORRECT_EN
  logic [CNT_W-1:0] err_count;
`endif

  node_core_engine #(.MY_IP(MY_IP), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .tx_count (tx_count),
    .rx_count (rx_count)
`ifdef HAMMING_CORRECT_EN
    ,
    .err_count(err_count)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Textbook Hamming: codeword position i (1-based) holds parity when i is a power of two.
  function automatic logic [6:0] ham_enc(input logic [3:0] d);
    logic [7:1] pos;
    pos    = '0;
    pos[3] = d[0];
    pos[5] = d[1];
    pos[6] = d[2];
    pos[7] = d[3];
    for (int p = 1; p <= 4; p = p * 2)
      for (int i = 1; i <= 7; i++)
        if (i != p && (i & p) != 0) pos[p] = pos[p] ^ pos[i];
    return pos;
  endfunction

  // Error position = XOR of the indices of all set bits.
  function automatic logic [3:0] ham_dec(input logic [6:0] cw_in, input bit correct, output bit fixed);
    logic [6:0] cw;
    int e;
    cw = cw_in;
    e  = 0;
    for (int i = 1; i <= 7; i++) if (cw[i-1]) e = e ^ i;
    fixed = correct && (e != 0);
    if (fixed) cw[e-1] = ~cw[e-1];
    return {cw[6], cw[5], cw[4], cw[2]};
  endfunction

  logic [10:0] pkt_q[$];
  logic [1:0]  ctrl_q[$];
  logic [7:0]  db_q[$];
  int m_tx, m_rx, m_err;

  task automatic idle_inputs();
    bus.dg_data        = 8'h00;
    bus.dg_valid       = 1'b0;
    bus.pkt_out_ready  = 1'b0;
    bus.ctrl_out_ready = 1'b0;
    bus.pkt_in_data    = 11'h000;
    bus.pkt_in_valid   = 1'b0;
    bus.db_ready       = 1'b0;
  endtask

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "_pkt_valid"},  32'(bus.pkt_out_valid),  0);
    chk({pfx, "_ctrl_valid"}, 32'(bus.ctrl_out_valid), 0);
    chk({pfx, "_db_valid"},   32'(bus.db_valid),       0);
    chk({pfx, "_pkt_data"},   32'(bus.pkt_out_data),   0);
    chk({pfx, "_db_data"},    32'(bus.db_data),        0);
    chk({pfx, "_tx_count"},   32'(tx_count),           0);
    chk({pfx, "_rx_count"},   32'(rx_count),           0);
    chk({pfx, "_dg_ready"},   32'(bus.dg_ready),       1);
    chk({pfx, "_pin_ready"},  32'(bus.pkt_in_ready),   1);
`ifdef HAMMING_CORRECT_EN
    chk({pfx, "_err_count"},  32'(err_count),          0);
`endif
  endtask

  initial begin
    bit dg_pend, pin_pend, fx, busy;
    bit e_rx_full, e_loop, e_dg_ready;
    bit x_pkt, x_ctrl, x_db, x_pin, x_dg;
    logic [3:0] pl;

    // Reset
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset_state("rst");

    // TX F2 with outputs stalled, ctrl held off for 5 cycles
    bus.dg_data  = 8'hF2;
    bus.dg_valid = 1'b1;
    #1 chk("tx_dg_ready", 32'(bus.dg_ready), 1);
    @(negedge clk);
    bus.dg_valid = 1'b0;
    #1;
    chk("tx_pkt_valid",  32'(bus.pkt_out_valid),  1);
    chk("tx_pkt_data",   32'(bus.pkt_out_data),   32'h799);
    chk("tx_ctrl_valid", 32'(bus.ctrl_out_valid), 1);
    chk("tx_ctrl_data",  32'(bus.ctrl_out_data),  1);
    chk("tx_full_ready", 32'(bus.dg_ready),       0);
    bus.pkt_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.pkt_out_ready = 1'b0;
      #1;
      chk("stall_dg_ready",   32'(bus.dg_ready),       0);
      chk("stall_pkt_data",   32'(bus.pkt_out_data),   32'h799);
      chk("stall_pkt_valid",  32'(bus.pkt_out_valid),  0);
      chk("stall_ctrl_valid", 32'(bus.ctrl_out_valid), 1);
      chk("stall_tx_count",   32'(tx_count),           0);
    end
    bus.ctrl_out_ready = 1'b1;
    @(negedge clk);
    bus.ctrl_out_ready = 1'b0;
    #1;
    chk("drain_ctrl_valid", 32'(bus.ctrl_out_valid), 0);
    chk("drain_dg_ready",   32'(bus.dg_ready),       1);
    chk("drain_tx_count",   32'(tx_count),           1);

    // RX 799
    bus.db_ready     = 1'b1;
    bus.pkt_in_data  = 11'h799;
    bus.pkt_in_valid = 1'b1;
    #1 chk("rx_pin_ready", 32'(bus.pkt_in_ready), 1);
    @(negedge clk);
    bus.pkt_in_valid = 1'b0;
    #1;
    chk("rx_db_valid",  32'(bus.db_valid),     1);
    chk("rx_db_data",   32'(bus.db_data),      32'hF2);
    chk("rx_full_rdy",  32'(bus.pkt_in_ready), 0);
    @(negedge clk);
    #1;
    chk("rx_db_done",   32'(bus.db_valid),     0);
    chk("rx_count1",    32'(rx_count),         1);

    // RX 798: p1 flipped, data bits intact
    bus.pkt_in_data  = 11'h798;
    bus.pkt_in_valid = 1'b1;
    @(negedge clk);
    bus.pkt_in_valid = 1'b0;
    #1;
    chk("rx_err_db_data", 32'(bus.db_data), 32'hF2);
`ifdef HAMMING_CORRECT_EN
    chk("rx_err_count", 32'(err_count), 1);
`endif
    @(negedge clk);
    #1 chk("rx_count2", 32'(rx_count), 2);

    // Loopback 25, then 27 blocked by the full RX buffer
    bus.db_ready       = 1'b0;
    bus.pkt_out_ready  = 1'b1;
    bus.ctrl_out_ready = 1'b1;
    bus.dg_data        = 8'h25;
    bus.dg_valid       = 1'b1;
    #1 chk("lb_dg_ready", 32'(bus.dg_ready), 1);
    @(negedge clk);
    bus.dg_data = 8'h27;
    #1;
    chk("lb_no_pkt",   32'(bus.pkt_out_valid),  0);
    chk("lb_no_ctrl",  32'(bus.ctrl_out_valid), 0);
    chk("lb_db_valid", 32'(bus.db_valid),       1);
    chk("lb_db_data",  32'(bus.db_data),        32'h25);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("lb_blocked", 32'(bus.dg_ready), 0);
      chk("lb_hold",    32'(bus.db_data),  32'h25);
    end
    bus.db_ready = 1'b1;
    @(negedge clk);
    bus.db_ready = 1'b0;
    #1;
    chk("lb_drained",  32'(bus.db_valid), 0);
    chk("lb_rx_count", 32'(rx_count),     3);
    chk("lb_ready",    32'(bus.dg_ready), 1);
    // pkt_in contends with loopback 27 and wins
    bus.pkt_in_data  = {4'h5, ham_enc(4'h9)};
    bus.pkt_in_valid = 1'b1;
    #1;
    chk("cont_dg_ready",  32'(bus.dg_ready),     0);
    chk("cont_pin_ready", 32'(bus.pkt_in_ready), 1);
    @(negedge clk);
    bus.pkt_in_valid = 1'b0;
    #1;
    chk("cont_db_data", 32'(bus.db_data),  32'h59);
    chk("cont_blocked", 32'(bus.dg_ready), 0);
    bus.db_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("cont_rx_count", 32'(rx_count),     4);
    chk("cont_lb_ready", 32'(bus.dg_ready), 1);
    @(negedge clk);
    bus.dg_valid = 1'b0;
    #1;
    chk("lb2_db_data",  32'(bus.db_data),  32'h27);
    chk("lb2_db_valid", 32'(bus.db_valid), 1);
    @(negedge clk);
    bus.db_ready = 1'b0;
    #1 chk("lb2_rx_count", 32'(rx_count), 5);

    // Reset while both buffers are full
    bus.pkt_out_ready  = 1'b0;
    bus.ctrl_out_ready = 1'b0;
    bus.dg_data        = 8'hA3;
    bus.dg_valid       = 1'b1;
    bus.pkt_in_data    = 11'h799;
    bus.pkt_in_valid   = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("full_pkt_valid", 32'(bus.pkt_out_valid), 1);
    chk("full_db_valid",  32'(bus.db_valid),      1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset_state("rst_full");

    // Randomized traffic against a queue scoreboard
    m_tx = 0; m_rx = 0; m_err = 0;
    pkt_q.delete(); ctrl_q.delete(); db_q.delete();
    dg_pend = 0; pin_pend = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (!dg_pend) begin
        bus.dg_valid = 1'($urandom_range(0, 1));
        bus.dg_data  = ($urandom_range(0, 2) == 0) ? {MY_IP, 4'($urandom)} : 8'($urandom);
      end
      if (!pin_pend) begin
        bus.pkt_in_valid = ($urandom_range(0, 2) == 0);
        bus.pkt_in_data  = 11'($urandom);
      end
      bus.pkt_out_ready  = ($urandom_range(0, 3) != 0);
      bus.ctrl_out_ready = ($urandom_range(0, 2) != 0);
      bus.db_ready       = ($urandom_range(0, 2) != 0);
      #1;
      busy       = (pkt_q.size() != 0) || (ctrl_q.size() != 0);
      e_rx_full  = (db_q.size() != 0);
      e_loop     = (bus.dg_data[7:4] == MY_IP);
      e_dg_ready = !busy && !(e_loop && (e_rx_full || bus.pkt_in_valid));

      chk("r_pkt_valid",  32'(bus.pkt_out_valid),  32'(pkt_q.size() != 0));
      if (pkt_q.size() != 0) chk("r_pkt_data", 32'(bus.pkt_out_data), 32'(pkt_q[0]));
      chk("r_ctrl_valid", 32'(bus.ctrl_out_valid), 32'(ctrl_q.size() != 0));
      if (ctrl_q.size() != 0) chk("r_ctrl_data", 32'(bus.ctrl_out_data), 32'(ctrl_q[0]));
      chk("r_db_valid",   32'(bus.db_valid),       32'(e_rx_full));
      if (e_rx_full) chk("r_db_data", 32'(bus.db_data), 32'(db_q[0]));
      chk("r_pin_ready",  32'(bus.pkt_in_ready),   32'(!e_rx_full));
      if (bus.dg_valid) chk("r_dg_ready", 32'(bus.dg_ready), 32'(e_dg_ready));
      chk("r_tx_count",   32'(tx_count), 32'(m_tx % (1 << CNT_W)));
      chk("r_rx_count",   32'(rx_count), 32'(m_rx % (1 << CNT_W)));
`ifdef HAMMING_CORRECT_EN
      chk("r_err_count",  32'(err_count), 32'(m_err % (1 << CNT_W)));
`endif

      x_pkt  = (pkt_q.size() != 0) && bus.pkt_out_ready;
      x_ctrl = (ctrl_q.size() != 0) && bus.ctrl_out_ready;
      x_db   = e_rx_full && bus.db_ready;
      x_pin  = bus.pkt_in_valid && !e_rx_full;
      x_dg   = bus.dg_valid && e_dg_ready;

      if (x_pkt)  void'(pkt_q.pop_front());
      if (x_ctrl) void'(ctrl_q.pop_front());
      if (busy && pkt_q.size() == 0 && ctrl_q.size() == 0) m_tx++;
      if (x_db) begin
        void'(db_q.pop_front());
        m_rx++;
      end
      if (x_pin) begin
        pl = ham_dec(bus.pkt_in_data[6:0], CORR, fx);
        db_q.push_back({bus.pkt_in_data[10:7], pl});
        if (fx) m_err++;
      end
      if (x_dg) begin
        if (e_loop) db_q.push_back(bus.dg_data);
        else begin
          pkt_q.push_back({bus.dg_data[7:4], ham_enc(bus.dg_data[3:0])});
          ctrl_q.push_back(2'b01);
        end
      end
      dg_pend  = bus.dg_valid && !x_dg;
      pin_pend = bus.pkt_in_valid && !x_pin;
    end
    @(negedge clk);
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
